// File: rtl/laser_host.sv
// Host-side driver and scorer for the two-circle laser coverage engine.
// Loads a point table, streams it to the engine, captures the centres and counts covered points.
module laser_host #(
    parameter int NPTS        = 40,
    parameter int RADIUS_SQ   = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       LOAD_EN,
    input  logic [5:0] LOAD_ADDR,
    input  logic [3:0] LOAD_X,
    input  logic [3:0] LOAD_Y,
    output logic       DUT_RST,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    input  logic       DONE,
    output logic       BUSY,
    output logic [5:0] COVER,
    output logic       RESULT_VALID,
    output logic       TIMEOUT
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_DUT, S_SEND, S_WAIT, S_SCORE, S_REPORT
    } state_t;

    localparam logic [5:0]  LAST_IDX = 6'(NPTS - 1);
    localparam logic [5:0]  NPTS_W   = 6'(NPTS);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [8:0]  RAD_W    = 9'(RADIUS_SQ);

    // Distances are unsigned magnitudes, so the square and sum never wrap.
    function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sqx;
        logic [7:0] sqy;
        logic [8:0] sum;
        dx  = (px >= cx) ? (px - cx) : (cx - px);
        dy  = (py >= cy) ? (py - cy) : (cy - py);
        sqx = {4'd0, dx} * {4'd0, dx};
        sqy = {4'd0, dy} * {4'd0, dy};
        sum = {1'b0, sqx} + {1'b0, sqy};
        return (sum <= RAD_W);
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  tab_q [NPTS];
    logic [5:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  x_q, x_d, y_q, y_d;
    logic        dut_rst_q, dut_rst_d;
    logic        busy_q, busy_d;
    logic [5:0]  cover_q, cover_d;
    logic        rv_q, rv_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
    logic [7:0]  pt_s;
    logic        covered_s;

    assign pt_s      = tab_q[idx_q];
    assign covered_s = in_circle(pt_s[7:4], pt_s[3:0], c1x_q, c1y_q) |
                       in_circle(pt_s[7:4], pt_s[3:0], c2x_q, c2y_q);

    // Point table: writable only while idle, out-of-range writes dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NPTS; i++) begin
                tab_q[i] <= 8'd0;
            end
        end else if ((state_q == S_IDLE) && LOAD_EN && (LOAD_ADDR < NPTS_W)) begin
            tab_q[LOAD_ADDR] <= {LOAD_X, LOAD_Y};
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        x_d       = 4'd0;
        y_d       = 4'd0;
        dut_rst_d = 1'b0;
        cover_d   = cover_q;
        rv_d      = 1'b0;
        timeout_d = timeout_q;
        c1x_d     = c1x_q;
        c1y_d     = c1y_q;
        c2x_d     = c2x_q;
        c2y_d     = c2y_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d   = S_RST_DUT;
                    dut_rst_d = 1'b1;
                    cover_d   = 6'd0;
                    timeout_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RST_DUT: begin
                state_d    = S_SEND;
                idx_d      = 6'd0;
                {x_d, y_d} = tab_q[0];
            end
            S_SEND: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_WAIT;
                    cnt_d   = 16'd0;
                end else begin
                    idx_d      = idx_q + 6'd1;
                    {x_d, y_d} = tab_q[idx_q + 6'd1];
                end
            end
            S_WAIT: begin
                if (DONE) begin
                    state_d = S_SCORE;
                    idx_d   = 6'd0;
                    c1x_d   = C1X;
                    c1y_d   = C1Y;
                    c2x_d   = C2X;
                    c2y_d   = C2Y;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_REPORT;
                    timeout_d = 1'b1;
                    cover_d   = 6'd0;
                    rv_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SCORE: begin
                if (covered_s) begin
                    cover_d = cover_q + 6'd1;
                end else begin
                    cover_d = cover_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_REPORT;
                    rv_d    = 1'b1;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            idx_q     <= 6'd0;
            cnt_q     <= 16'd0;
            x_q       <= 4'd0;
            y_q       <= 4'd0;
            dut_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            cover_q   <= 6'd0;
            rv_q      <= 1'b0;
            timeout_q <= 1'b0;
            c1x_q     <= 4'd0;
            c1y_q     <= 4'd0;
            c2x_q     <= 4'd0;
            c2y_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dut_rst_q <= dut_rst_d;
            busy_q    <= busy_d;
            cover_q   <= cover_d;
            rv_q      <= rv_d;
            timeout_q <= timeout_d;
            c1x_q     <= c1x_d;
            c1y_q     <= c1y_d;
            c2x_q     <= c2x_d;
            c2y_q     <= c2y_d;
        end
    end

    assign DUT_RST      = dut_rst_q;
    assign X            = x_q;
    assign Y            = y_q;
    assign BUSY         = busy_q;
    assign COVER        = cover_q;
    assign RESULT_VALID = rv_q;
    assign TIMEOUT      = timeout_q;

endmodule

// File: tb/tb_laser_host.sv
// Self-checking bench for laser_host: table-driven runs plus hand-written corner sequences.
module tb_laser_host;

    localparam int NPTS        = 40;
    localparam int TIMEOUT_CYC = 4096;

    logic       CLK = 1'b0;
    logic       RST, START, LOAD_EN, DONE;
    logic [5:0] LOAD_ADDR;
    logic [3:0] LOAD_X, LOAD_Y, C1X, C1Y, C2X, C2Y;
    logic       DUT_RST, BUSY, RESULT_VALID, TIMEOUT;
    logic [3:0] X, Y;
    logic [5:0] COVER;

    laser_host #(.NPTS(NPTS), .RADIUS_SQ(16), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR),
        .LOAD_X(LOAD_X), .LOAD_Y(LOAD_Y), .DUT_RST(DUT_RST), .X(X), .Y(Y),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE), .BUSY(BUSY),
        .COVER(COVER), .RESULT_VALID(RESULT_VALID), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]       fill;
        int               nsp;
        logic [3:0][7:0]  sp;
        logic [3:0]       c1x, c1y, c2x, c2y;
        bit               done_en;
        int               exp_cover;
        bit               exp_to;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] tb_tab[NPTS];
    logic [7:0] q_xy[$];
    int         q_cov[$];
    int         n_chk = 0;
    int         n_err = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_one(input int addr, input logic [7:0] xy);
        LOAD_EN   = 1'b1;
        LOAD_ADDR = 6'(addr);
        {LOAD_X, LOAD_Y} = xy;
        step();
        LOAD_EN = 1'b0;
        if (addr < NPTS) tb_tab[addr] = xy;
    endtask

    task automatic load_tab(input logic [7:0] fill, input int nsp, input logic [3:0][7:0] sp);
        for (int a = 0; a < NPTS; a++) begin
            load_one(a, (a < nsp) ? sp[a] : fill);
        end
    endtask

    task automatic do_run(input logic [3:0] c1x, input logic [3:0] c1y,
                          input logic [3:0] c2x, input logic [3:0] c2y,
                          input bit done_en, input int exp_cover, input bit exp_to,
                          input int disturb, input int rst_at,
                          input bit sim_ld, input int sim_addr, input logic [7:0] sim_xy);
        logic [7:0] e;
        int         lat;
        bit         got;
        if (sim_ld && sim_addr < NPTS) tb_tab[sim_addr] = sim_xy;
        for (int i = 0; i < NPTS; i++) q_xy.push_back(tb_tab[i]);
        q_cov.push_back(exp_cover);
        START     = 1'b1;
        LOAD_EN   = sim_ld;
        LOAD_ADDR = 6'(sim_addr);
        {LOAD_X, LOAD_Y} = sim_xy;
        step();
        START   = 1'b0;
        LOAD_EN = 1'b0;
        chk("dut_rst_pulse", DUT_RST, 1);
        chk("busy_start", BUSY, 1);
        chk("cover_cleared", COVER, 0);
        chk("timeout_cleared", TIMEOUT, 0);
        for (int i = 0; i < NPTS; i++) begin
            step();
            e = q_xy.pop_front();
            chk("stream_x", X, e[7:4]);
            chk("stream_y", Y, e[3:0]);
            chk("dut_rst_low", DUT_RST, 0);
            if (i == rst_at) begin
                RST = 1'b1;
                step();
                chk("rst_dut_rst", DUT_RST, 1);
                chk("rst_busy", BUSY, 0);
                chk("rst_x", X, 0);
                chk("rst_y", Y, 0);
                chk("rst_cover", COVER, 0);
                RST = 1'b0;
                q_xy.delete();
                q_cov.delete();
                for (int a = 0; a < NPTS; a++) tb_tab[a] = 8'd0;
                step();
                return;
            end
            if (i == disturb) begin
                START = 1'b1; LOAD_EN = 1'b1; LOAD_ADDR = 6'd0;
                LOAD_X = 4'd9; LOAD_Y = 4'd9; DONE = 1'b1;
            end else begin
                START = 1'b0; LOAD_EN = 1'b0; DONE = 1'b0;
            end
        end
        START = 1'b0; LOAD_EN = 1'b0; DONE = 1'b0;
        step();
        chk("wait_x_zero", X, 0);
        chk("wait_y_zero", Y, 0);
        chk("wait_busy", BUSY, 1);
        if (done_en) begin
            C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y; DONE = 1'b1;
            step();
            DONE = 1'b0;
            C1X = ~c1x; C1Y = ~c1y; C2X = ~c2x; C2Y = ~c2y;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < TIMEOUT_CYC + 100) begin
            step();
            lat++;
            if (RESULT_VALID) got = 1'b1;
        end
        chk("result_valid_seen", got, 1);
        chk("report_latency", lat, done_en ? NPTS : TIMEOUT_CYC);
        chk("cover", COVER, q_cov.pop_front());
        chk("timeout_flag", TIMEOUT, exp_to);
        step();
        chk("result_valid_one_cycle", RESULT_VALID, 0);
        chk("busy_idle", BUSY, 0);
        chk("cover_hold", COVER, exp_cover);
        chk("timeout_hold", TIMEOUT, exp_to);
    endtask

    initial begin
        vecs[0] = '{8'h55, 0, 32'h0000_0000, 4'd5, 4'd5, 4'd12, 4'd12, 1'b1, 40, 1'b0};
        vecs[1] = '{8'hFF, 4, 32'h0088_5995, 4'd5, 4'd5, 4'd0, 4'd15, 1'b1, 2, 1'b0};
        vecs[2] = '{8'h11, 0, 32'h0000_0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 1'b1};
        vecs[3] = '{8'hFF, 1, 32'h0000_0033, 4'd3, 4'd3, 4'd3, 4'd3, 1'b1, 1, 1'b0};
        vecs[4] = '{8'h40, 1, 32'h0000_0041, 4'd0, 4'd0, 4'd15, 4'd15, 1'b1, 39, 1'b0};

        RST = 1'b1; START = 1'b0; LOAD_EN = 1'b0; DONE = 1'b0;
        LOAD_ADDR = 6'd0; LOAD_X = 4'd0; LOAD_Y = 4'd0;
        C1X = 4'd0; C1Y = 4'd0; C2X = 4'd0; C2Y = 4'd0;
        for (int a = 0; a < NPTS; a++) tb_tab[a] = 8'd0;
        step();
        step();
        chk("reset_dut_rst", DUT_RST, 1);
        chk("reset_x", X, 0);
        chk("reset_y", Y, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_cover", COVER, 0);
        chk("reset_rv", RESULT_VALID, 0);
        chk("reset_timeout", TIMEOUT, 0);
        RST = 1'b0;
        step();
        chk("idle_dut_rst", DUT_RST, 0);

        // Table-driven runs; the timeout run is followed by a START that must clear TIMEOUT.
        for (int v = 0; v < 5; v++) begin
            load_tab(vecs[v].fill, vecs[v].nsp, vecs[v].sp);
            do_run(vecs[v].c1x, vecs[v].c1y, vecs[v].c2x, vecs[v].c2y, vecs[v].done_en,
                   vecs[v].exp_cover, vecs[v].exp_to, -1, -1, 1'b0, 0, 8'h00);
        end

        // START, LOAD_EN and DONE pulsed during SEND are ignored.
        load_tab(8'h22, 0, 32'h0);
        do_run(4'd2, 4'd2, 4'd15, 4'd15, 1'b1, 40, 1'b0, 10, -1, 1'b0, 0, 8'h00);
        // Out-of-range write in IDLE is dropped; rerun proves index 0 kept its old value.
        load_one(45, 8'h99);
        do_run(4'd2, 4'd2, 4'd15, 4'd15, 1'b1, 40, 1'b0, -1, -1, 1'b0, 0, 8'h00);

        // Write in the START cycle is used by the run.
        load_tab(8'h66, 0, 32'h0);
        do_run(4'd6, 4'd6, 4'd15, 4'd15, 1'b1, 39, 1'b0, -1, -1, 1'b1, 0, 8'h12);

        // Reset mid-SEND clears the table; then a run on the cleared table, then a reloaded run.
        load_tab(8'h77, 0, 32'h0);
        do_run(4'd7, 4'd7, 4'd7, 4'd7, 1'b1, 40, 1'b0, -1, 20, 1'b0, 0, 8'h00);
        chk("post_rst_idle_dut_rst", DUT_RST, 0);
        do_run(4'd0, 4'd0, 4'd15, 4'd15, 1'b1, 40, 1'b0, -1, -1, 1'b0, 0, 8'h00);
        load_tab(vecs[0].fill, vecs[0].nsp, vecs[0].sp);
        do_run(vecs[0].c1x, vecs[0].c1y, vecs[0].c2x, vecs[0].c2y, 1'b1,
               40, 1'b0, -1, -1, 1'b0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/laser_host.md
Name: laser_host

Overview:
- Host-side driver and scorer for the two-circle laser coverage engine.
- Holds a loadable table of target points and resets the engine with a one-cycle pulse.
- Streams the points to the engine one per cycle, waits for DONE, then captures both circle centres.
- Scores the result by counting the points covered by either circle, and reports the count with a valid strobe.

Parameters:
- NPTS, 40, number of target points streamed per run (address width fixed at 6 bits).
- RADIUS_SQ, 16, squared coverage radius; a point is covered when dx^2+dy^2 <= RADIUS_SQ.
- TIMEOUT_CYC, 4096, maximum WAIT cycles before the run is abandoned (counter 16 bits).

Ports:
- CLK  input  1  system clock, all logic rising-edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  begins a run; sampled only in IDLE.
- LOAD_EN  input  1  writes the point table; honoured only in IDLE.
- LOAD_ADDR  input  6  table index; writes with index >= NPTS are dropped.
- LOAD_X  input  4  point X coordinate to write.
- LOAD_Y  input  4  point Y coordinate to write.
- DUT_RST  output  1  reset to the engine (registered).
- X  output  4  streamed point X (registered).
- Y  output  4  streamed point Y (registered).
- C1X, C1Y, C2X, C2Y  input  4 each  circle centres from the engine.
- DONE  input  1  engine result-valid.
- BUSY  output  1  high in every state except IDLE.
- COVER  output  6  covered-point count, 0..NPTS.
- RESULT_VALID  output  1  one-cycle strobe when COVER is final.
- TIMEOUT  output  1  sticky flag, set when a run is abandoned.

Behaviour:
- Reset values:
  - DUT_RST=1 (engine held in reset); X=0, Y=0, BUSY=0, COVER=0, RESULT_VALID=0, TIMEOUT=0.
  - State=IDLE; point table all zeros; captured centres 0.
- FSM states: IDLE, RST_DUT, SEND, WAIT, SCORE, REPORT.
- IDLE:
  - DUT_RST=0, X=Y=0.
  - LOAD_EN writes table[LOAD_ADDR]={LOAD_X,LOAD_Y}.
  - START=1 moves to RST_DUT and clears COVER and TIMEOUT.
  - LOAD_EN and START in the same cycle: the write completes; the run uses the new value.
- RST_DUT: DUT_RST=1 for exactly one cycle, then SEND.
- SEND:
  - Index i runs 0..NPTS-1; X,Y=table[i] in consecutive cycles, with no gaps.
  - If DUT_RST is high in cycle k, point i is on X,Y in cycle k+1+i.
  - After the last point, go to WAIT; X,Y return to 0.
  - DONE is ignored in SEND.
- WAIT:
  - Counts cycles. DONE=1 latches C1X..C2Y that same cycle and goes to SCORE.
  - If the count reaches TIMEOUT_CYC without DONE: TIMEOUT=1, COVER=0, go to REPORT.
  - DONE and timeout in the same cycle: DONE wins.
- SCORE:
  - Handles one point per cycle, NPTS cycles total.
  - Per point: dx=|px-cx| (4-bit unsigned, no wrap); square is 8 bits; sum is 9 bits. Same for dy.
  - Compare the sum <= RADIUS_SQ (unsigned) against each circle.
  - covered = in C1 OR in C2. A point inside both circles counts once.
  - COVER accumulates by 1 per covered point and saturates naturally at NPTS.
- REPORT: RESULT_VALID=1 for one cycle, then IDLE. COVER and TIMEOUT hold until the next START or RST.
- START outside IDLE is ignored; LOAD_EN outside IDLE is ignored, and the table is unchanged.
- RST in any state, including mid-SEND or mid-SCORE:
  - All registers return to their reset values on the next edge.
  - Partial counts are discarded; the point table is cleared.

Test Plan:
- Load all 40 points = (5,5); START; engine model returns C1=(5,5), C2=(12,12) -> DUT_RST pulse 1 cycle, 40 consecutive X,Y=(5,5), RESULT_VALID once, COVER=40, TIMEOUT=0.
- Load points (9,5), (5,9), (8,8), (0,0) with the remaining 36 at (15,15); C1=(5,5), C2=(0,15) -> (9,5) and (5,9) are covered at exactly distance 4, (8,8) is not (18>16), (0,0) is not -> COVER=2.
- Point (3,3) with C1=C2=(3,3), remaining points far away -> the double-covered point counts once, COVER=1.
- DONE never asserted -> after TIMEOUT_CYC WAIT cycles: TIMEOUT=1, RESULT_VALID pulse, COVER=0. A following START clears TIMEOUT.
- START and LOAD_EN pulsed during SEND -> stream unchanged and the table still holds the old value; a LOAD_ADDR=45 write in IDLE has no effect.
- RST asserted at SEND index 20 -> next cycle DUT_RST=1, BUSY=0, X=Y=0, COVER=0; a new START after reloading the table completes normally.
